// File: rtl/mealy_seq_detector.sv
// Mealy serial pattern detector. The state is the number of pattern bits
// matched so far; all next-state arcs (including KMP failure arcs) are
// derived from PATTERN by constant functions and fold into plain logic.
module mealy_seq_detector #(
  parameter int                     PATTERN_LEN = 4,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b0011,
  parameter bit                     OVERLAP     = 1'b1
) (
  output logic OUT,
  input  logic IN,
  input  logic CLOCK,
  input  logic RESET
);

  localparam int SW = $clog2(PATTERN_LEN);

  typedef logic [SW-1:0] state_t;

  localparam state_t LAST = SW'(PATTERN_LEN - 1);

  state_t state;
  state_t state_nxt;

  // Pattern bit in arrival order: index 0 is the first bit received (MSB).
  function automatic logic pat_bit(input int i);
    logic [PATTERN_LEN-1:0] sh;
    sh = PATTERN >> (PATTERN_LEN - 1 - i);
    return sh[0];
  endfunction

  // Longest proper suffix of the whole pattern that is also a prefix.
  function automatic int border();
    int   best;
    logic ok;
    best = 0;
    for (int l = 1; l < PATTERN_LEN; l++) begin
      ok = 1'b1;
      for (int j = 0; j < PATTERN_LEN; j++) begin
        if (j < l && pat_bit(PATTERN_LEN - l + j) != pat_bit(j)) ok = 1'b0;
      end
      if (ok) best = l;
    end
    return best;
  endfunction

  // Next match length after seeing bit b with k bits matched: the longest
  // suffix of (prefix[0..k-1], b) that is a prefix of the pattern. A full
  // match collapses to the border (overlapping) or to idle.
  function automatic int kmp_next(input int k, input logic b);
    int   best;
    int   idx;
    logic ok;
    logic sv;
    best = 0;
    for (int l = 1; l <= PATTERN_LEN; l++) begin
      if (l <= k + 1) begin
        ok = 1'b1;
        for (int j = 0; j < PATTERN_LEN; j++) begin
          if (j < l) begin
            idx = k + 1 - l + j;
            sv  = (idx < k) ? pat_bit(idx) : b;
            if (sv != pat_bit(j)) ok = 1'b0;
          end
        end
        if (ok) best = l;
      end
    end
    if (best == PATTERN_LEN) best = OVERLAP ? border() : 0;
    return best;
  endfunction

  // Next-state decode; unused codes fall through to idle.
  always_comb begin
    state_nxt = '0;
    for (int k = 0; k < PATTERN_LEN; k++) begin
      if (state == SW'(k)) begin
        state_nxt = IN ? SW'(kmp_next(k, 1'b1)) : SW'(kmp_next(k, 1'b0));
      end
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge CLOCK) begin
    if (!RESET) state <= '0;
    else        state <= state_nxt;
  end

  // Zero-latency match flag, suppressed while reset is asserted.
  assign OUT = RESET && (state == LAST) && (IN == PATTERN[0]);

endmodule

// File: tb/tb_mealy_seq_detector.sv
// Scoreboard bench for mealy_seq_detector: four configurations share one
// input stream; a history-based model predicts each cycle's match flags.
module tb_mealy_seq_detector;

  logic clk  = 1'b0;
  logic rst  = 1'b0;
  logic din  = 1'b0;
  logic out0, out1, out2, out3;

  int checks   = 0;
  int failures = 0;

  logic [3:0] exp_q[$];

  int    lens[4]  = '{4, 4, 4, 5};
  int    pats[4]  = '{32'h3, 32'hB, 32'hB, 32'h16};
  bit    ovs[4]   = '{1'b1, 1'b1, 1'b0, 1'b1};
  string names[4] = '{"p0011_ov1", "p1011_ov1", "p1011_ov0", "p10110_ov1"};

  int hist[4] = '{0, 0, 0, 0};
  int cnt[4]  = '{0, 0, 0, 0};
  int cycle   = 0;

  mealy_seq_detector #(.PATTERN_LEN(4), .PATTERN(4'b0011), .OVERLAP(1'b1)) dut0 (
    .OUT(out0), .IN(din), .CLOCK(clk), .RESET(rst));
  mealy_seq_detector #(.PATTERN_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1)) dut1 (
    .OUT(out1), .IN(din), .CLOCK(clk), .RESET(rst));
  mealy_seq_detector #(.PATTERN_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0)) dut2 (
    .OUT(out2), .IN(din), .CLOCK(clk), .RESET(rst));
  mealy_seq_detector #(.PATTERN_LEN(5), .PATTERN(5'b10110), .OVERLAP(1'b1)) dut3 (
    .OUT(out3), .IN(din), .CLOCK(clk), .RESET(rst));

  always #5 clk = ~clk;

  // One cycle of stimulus: drive inputs at the falling edge and push the
  // model's expected flags. A match is "the last LEN bits seen since the
  // last reset (or last match, when not overlapping) equal the pattern".
  task automatic step(input logic r, input logic b);
    logic [3:0] e;
    int         mask;
    logic       m;
    @(negedge clk);
    rst = r;
    din = b;
    e   = '0;
    for (int i = 0; i < 4; i++) begin
      mask = (1 << lens[i]) - 1;
      m = r && (cnt[i] >= lens[i] - 1) &&
          (((((hist[i] << 1) | int'(b)) & mask)) == pats[i]);
      e = e | (4'(m) << i);
      if (!r) begin
        hist[i] = 0;
        cnt[i]  = 0;
      end else if (m && !ovs[i]) begin
        hist[i] = 0;
        cnt[i]  = 0;
      end else begin
        hist[i] = (hist[i] << 1) | int'(b);
        cnt[i]  = cnt[i] + 1;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic play(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b1, 1'(bits >> i));
  endtask

  // Monitor: the flag is valid every cycle; compare mid-low-phase.
  initial begin
    logic [3:0] e;
    logic [3:0] act;
    forever begin
      @(negedge clk);
      #2;
      cycle++;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {out3, out2, out1, out0};
        for (int i = 0; i < 4; i++) begin
          checks++;
          if (1'(act >> i) !== 1'(e >> i)) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0b required=%0b",
                     names[i], cycle, 1'(act >> i), 1'(e >> i));
          end
        end
      end
    end
  end

  initial begin
    bit drained;
    // Reset held while a full pattern is presented.
    step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b1); step(1'b0, 1'b1);
    play(16'b0011, 4);
    step(1'b0, 1'b0);
    play(16'b0011_0000_1100, 12);
    repeat (20) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    play(16'b00011, 5);
    step(1'b0, 1'b0);
    play(16'b0010011, 7);
    step(1'b0, 1'b0);
    play(16'b1011011, 7);
    step(1'b0, 1'b0);
    play(16'b001, 3);
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    play(16'b0011, 4);
    step(1'b0, 1'b0);
    play(16'b1011010110, 10);

    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 15))
        0:       step(1'b0, 1'($urandom_range(0, 1)));
        1:       play(16'b0011, 4);
        2:       play(16'b1011, 4);
        3:       play(16'b10110, 5);
        default: step(1'b1, 1'($urandom_range(0, 1)));
      endcase
    end

    drained = 1'b0;
    for (int w = 0; w < 10 && !drained; w++) begin
      @(negedge clk);
      #3;
      if (exp_q.size() == 0) drained = 1'b1;
    end
    checks++;
    if (!drained) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
